dp_result_serializer: RTL
=========================

DP_RESULT_SERIALIZER -- requirements
Module: dp_result_serializer

Interface
REQ-001 SHALL have parameter DATA_W, default 32, width of each result word (x, z).
REQ-002 SHALL have parameter DEPTH, default 4, number of {x,z} entries buffered; power of two, at least 2.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  producer has a result pair this cycle.
REQ-006 SHALL have port in_x  input  DATA_W  signed x result from the upstream datapath.
REQ-007 SHALL have port in_z  input  DATA_W  signed z result from the upstream datapath.
REQ-008 SHALL have port in_ready  output  1  block accepts a pair this cycle.
REQ-009 SHALL have port out_valid  output  1  out_data holds a valid beat.
REQ-010 SHALL have port out_ready  input  1  consumer accepts the current beat.
REQ-011 SHALL have port out_data  output  DATA_W  serialized beat, x then z.
REQ-012 SHALL have port out_last  output  1  high on the z beat of a pair.

Function
REQ-013 SHALL accept a pair (push) on any cycle with in_valid and in_ready both high.
REQ-014 SHALL drive in_ready = (count < DEPTH), registered; a push is refused when full even if a pop occurs in the same cycle.
REQ-015 SHALL drive out_valid high whenever count > 0; no empty bypass, so minimum in-to-out latency is 1 cycle.
REQ-016 SHALL use a two-state FSM: PH_X (out_data = head.x, out_last = 0) and PH_Z (out_data = head.z, out_last = 1).
REQ-017 SHALL move PH_X -> PH_Z on an out_valid && out_ready beat, and PH_Z -> PH_X on such a beat; otherwise hold.
REQ-018 SHALL pop the head entry only on the PH_Z handshake.
REQ-019 SHALL hold out_data and out_last stable while out_valid && !out_ready.
REQ-020 SHALL, on a simultaneous push and pop with count < DEPTH, leave count unchanged and advance both pointers.
REQ-021 SHALL wrap read and write pointers modulo DEPTH.
REQ-022 SHALL store in_x and in_z unmodified (no width change or sign manipulation).

Reset
REQ-023 SHALL, with rst high at a clock edge, set count = 0, pointers = 0, phase = PH_X, out_valid = 0, out_last = 0, in_ready = 1, and out_data = 0.
REQ-024 SHALL discard buffered entries and any half-sent pair when rst is asserted mid-operation; storage contents need not be cleared.

Configuration
REQ-025 SHALL, with macro DP_RESULT_SUM_EN defined, add input sum_clr (1) and output sum_out (DATA_W+16, signed); each push adds sign-extended in_x + in_z, wrapping modulo 2^(DATA_W+16); sum_clr takes priority and, when coinciding with a push, sets sum_out to that pair's sum. rst clears sum_out to 0.
REQ-026 SHALL, without DP_RESULT_SUM_EN, contain neither port nor accumulator logic.

Structure
REQ-027 SHALL take DATA_W and DEPTH defaults and the phase enum typedef (PH_X, PH_Z) from shared package dp_result_pkg.
REQ-028 SHALL place the DEPTH x 2*DATA_W storage array in sub-module dp_result_mem (one write port, one async read port).

Verification
REQ-029 SHALL cover: reset, then push x=5, z=-3 with out_ready=1 -> beats 5 (last=0), -3 (last=1) on cycles 1 and 2.
REQ-030 SHALL cover: 4 pushes with out_ready=0 -> in_ready=0 after the 4th; a 5th in_valid is not accepted; count stays 4.
REQ-031 SHALL cover: full FIFO, push attempt during the PH_Z pop -> push refused, in_ready=1 next cycle.
REQ-032 SHALL cover: out_ready toggled every other cycle over 3 pairs -> out_data stable while stalled, order x0,z0,x1,z1,x2,z2.
REQ-033 SHALL cover: rst asserted after the x beat of a pair -> next cycle out_valid=0, phase PH_X, in_ready=1.
REQ-034 SHALL cover (DP_RESULT_SUM_EN): push (0x7FFFFFFF, 1) then (-10, 4) -> sum_out = 0x80000000 - 6 = 0x7FFFFFFA; sum_clr with push (2, 3) -> sum_out = 5.

Source files
------------

// File: rtl/dp_result_pkg.sv
// Shared defaults and phase encoding for the result serializer.
// Optional running-sum feature is enabled by defining DP_RESULT_SUM_EN.
package dp_result_pkg;
    localparam int DATA_W_DEF = 32;
    localparam int DEPTH_DEF  = 4;

    typedef enum logic {
        PH_X = 1'b0,
        PH_Z = 1'b1
    } phase_t;
endpackage

// File: rtl/dp_result_mem.sv
// Pair storage: one synchronous write port, one asynchronous read port.
module dp_result_mem #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [AW-1:0]         waddr,
    input  logic [2*DATA_W-1:0]   wdata,
    input  logic [AW-1:0]         raddr,
    output logic [2*DATA_W-1:0]   rdata
);
    logic [2*DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/dp_result_serializer.sv
// Buffers {x,z} result pairs and emits them as two beats, x then z.
// Define DP_RESULT_SUM_EN to add the sum_clr / sum_out running accumulator.
module dp_result_serializer
    import dp_result_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_x,
    input  logic [DATA_W-1:0] in_z,
    output logic              in_ready,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
`ifdef DP_RESULT_SUM_EN
    input  logic              sum_clr,
    output logic signed [DATA_W+15:0] sum_out,
`endif
    output logic              out_last
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0]       wr_ptr, rd_ptr;
    logic [CW-1:0]       count, count_nxt;
    phase_t              phase;
    logic [2*DATA_W-1:0] head;
    logic                push, beat, pop;

    // in_ready reflects count from the previous edge, so a full buffer
    // refuses a push even while the head is popping.
    assign push = in_valid && in_ready;
    assign beat = out_valid && out_ready;
    assign pop  = beat && (phase == PH_Z);

    always_comb begin
        count_nxt = count;
        if (push && !pop)
            count_nxt = count + CW'(1);
        else if (pop && !push)
            count_nxt = count - CW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            phase     <= PH_X;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            if (beat)
                phase <= (phase == PH_X) ? PH_Z : PH_X;
            count     <= count_nxt;
            in_ready  <= (count_nxt < CW'(DEPTH));
            out_valid <= (count_nxt != '0);
        end
    end

    dp_result_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr),
        .wdata ({in_z, in_x}),
        .raddr (rd_ptr),
        .rdata (head)
    );

    // Head only changes on a pop, so the beat is stable while stalled.
    assign out_data = !out_valid ? '0 :
                      (phase == PH_Z) ? head[2*DATA_W-1:DATA_W] : head[DATA_W-1:0];
    assign out_last = out_valid && (phase == PH_Z);

`ifdef DP_RESULT_SUM_EN
    localparam int SW = DATA_W + 16;
    logic [SW-1:0] pair_sum;

    assign pair_sum = {{16{in_x[DATA_W-1]}}, in_x} + {{16{in_z[DATA_W-1]}}, in_z};

    always_ff @(posedge clk) begin
        if (rst)
            sum_out <= '0;
        else if (sum_clr)
            sum_out <= push ? signed'(pair_sum) : '0;
        else if (push)
            sum_out <= sum_out + signed'(pair_sum);
    end
`endif
endmodule
